// File: rtl/rtc_sevensegmux.sv
// Six-digit multiplexed seven-segment driver for a BCD stopwatch count, with per-frame snapshot.
// Optional leading-zero blanking of the three upper digits is enabled by defining RTC_LZBLANK_EN.
module rtc_sevensegmux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [23:0] i_count,
  input  logic        i_blank,
  output logic [5:0]  o_anode_n,
  output logic [6:0]  o_seg_n,
  output logic        o_dp_n,
  output logic        o_frame
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] slot_cnt_reg;
  logic [2:0]    idx_reg;
  logic [23:0]   snap_reg;

  logic          slot_wrap;
  logic          frame_wrap;
  logic [3:0]    digit;
  logic          digit_blank;
  logic [5:0]    anode_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx_reg == 3'd5);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    case (idx_reg)
      3'd0:    digit = snap_reg[3:0];
      3'd1:    digit = snap_reg[7:4];
      3'd2:    digit = snap_reg[11:8];
      3'd3:    digit = snap_reg[15:12];
      3'd4:    digit = snap_reg[19:16];
      default: digit = snap_reg[23:20];
    endcase
  end

`ifdef RTC_LZBLANK_EN
  // A digit is a leading zero only if it and every more significant digit are zero.
  always_comb begin
    case (idx_reg)
      3'd5:    digit_blank = (snap_reg[23:20] == 4'd0);
      3'd4:    digit_blank = (snap_reg[23:16] == 8'd0);
      3'd3:    digit_blank = (snap_reg[23:12] == 12'd0);
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  // Slot count 0 is the dead cycle that keeps the previous digit from ghosting.
  always_comb begin
    if ((slot_cnt_reg == '0) || i_blank || digit_blank)
      anode_next = 6'b111111;
    else
      anode_next = ~(6'd1 << idx_reg);
    seg_next = digit_blank ? 7'b1111111 : seg_decode(digit);
    dp_next  = ~(((idx_reg == 3'd2) || (idx_reg == 3'd4)) && !digit_blank);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      slot_cnt_reg <= '0;
      idx_reg      <= 3'd0;
      snap_reg     <= 24'd0;
      o_anode_n    <= 6'b111111;
      o_seg_n      <= 7'b1111111;
      o_dp_n       <= 1'b1;
      o_frame      <= 1'b0;
    end else begin
      slot_cnt_reg <= slot_wrap ? '0 : slot_cnt_reg + CW'(1);
      if (slot_wrap)
        idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
      if (frame_wrap)
        snap_reg <= i_count;
      o_frame   <= frame_wrap;
      o_anode_n <= anode_next;
      o_seg_n   <= seg_next;
      o_dp_n    <= dp_next;
    end
  end

endmodule

// File: tb/tb_rtc_sevensegmux.sv
// Directed bench for rtc_sevensegmux with REFRESH_DIV=4 (one frame = 24 cycles).
// Expectations for the upper digits of 24'h000512 depend on RTC_LZBLANK_EN.
module tb_rtc_sevensegmux;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] count;
  logic        blank;
  logic [5:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_sevensegmux #(.REFRESH_DIV(4)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_count   (count),
    .i_blank   (blank),
    .o_anode_n (anode_n),
    .o_seg_n   (seg_n),
    .o_dp_n    (dp_n),
    .o_frame   (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] count;
    int          idx;
    logic [5:0]  anode;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [23:0] c, input int i, input logic [5:0] a,
                              input logic [6:0] s, input logic d);
    vec_t v;
    v.count = c; v.idx = i; v.anode = a; v.seg = s; v.dp = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where o_frame is seen high; a missing pulse is a failure.
  task automatic wait_frame(input string name);
    bit found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (frame) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no o_frame pulse within 60 cycles", name);
    end
  endtask

  // Cycles until the next o_frame pulse (0 if none within 60).
  task automatic frame_gap(output int gap);
    gap = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (frame) begin
        gap = c;
        break;
      end
    end
  endtask

  initial begin
    int gap;
    int seen_at;

    vecs[0]  = mk(24'h012345, 0, 6'b111110, 7'b0010010, 1'b1);
    vecs[1]  = mk(24'h012345, 1, 6'b111101, 7'b0011001, 1'b1);
    vecs[2]  = mk(24'h012345, 2, 6'b111011, 7'b0110000, 1'b0);
    vecs[3]  = mk(24'h012345, 3, 6'b110111, 7'b0100100, 1'b1);
    vecs[4]  = mk(24'h012345, 4, 6'b101111, 7'b1111001, 1'b0);
    vecs[5]  = mk(24'h012345, 5, 6'b011111, 7'b1000000, 1'b1);
    vecs[6]  = mk(24'hFA0000, 5, 6'b011111, 7'b0111111, 1'b1);
    vecs[7]  = mk(24'hFA0000, 4, 6'b101111, 7'b0111111, 1'b0);
    vecs[8]  = mk(24'hFA0000, 0, 6'b111110, 7'b1000000, 1'b1);
    vecs[9]  = mk(24'h678900, 5, 6'b011111, 7'b0000010, 1'b1);
    vecs[10] = mk(24'h678900, 4, 6'b101111, 7'b1111000, 1'b0);
    vecs[11] = mk(24'h678900, 3, 6'b110111, 7'b0000000, 1'b1);
`ifdef RTC_LZBLANK_EN
    vecs[12] = mk(24'h000512, 5, 6'b111111, 7'b1111111, 1'b1);
    vecs[13] = mk(24'h000512, 4, 6'b111111, 7'b1111111, 1'b1);
    vecs[14] = mk(24'h000512, 3, 6'b111111, 7'b1111111, 1'b1);
`else
    vecs[12] = mk(24'h000512, 5, 6'b011111, 7'b1000000, 1'b1);
    vecs[13] = mk(24'h000512, 4, 6'b101111, 7'b1000000, 1'b0);
    vecs[14] = mk(24'h000512, 3, 6'b110111, 7'b1000000, 1'b1);
`endif
    vecs[15] = mk(24'h000512, 2, 6'b111011, 7'b0010010, 1'b0);

    // Power-on reset and first slot after release
    rst = 1'b1; count = 24'h012345; blank = 1'b0;
    #1;
    check("por_anode", 32'(anode_n), 32'h3F);
    check("por_seg",   32'(seg_n),   32'h7F);
    check("por_dp",    32'(dp_n),    32'h1);
    check("por_frame", 32'(frame),   32'h0);
    step(3);
    rst = 1'b0;
    step(1);
    check("rel_dead_anode", 32'(anode_n), 32'h3F);
    step(1);
    check("rel_idx0_anode", 32'(anode_n), 32'h3E);
    check("rel_snap_zero_seg", 32'(seg_n), 32'h40);

    // Reset asserted mid-slot takes effect without a clock edge
    step(5);
    rst = 1'b1;
    #1;
    check("mid_rst_anode", 32'(anode_n), 32'h3F);
    check("mid_rst_seg",   32'(seg_n),   32'h7F);
    check("mid_rst_dp",    32'(dp_n),    32'h1);
    check("mid_rst_frame", 32'(frame),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("mid_rel_dead", 32'(anode_n), 32'h3F);
    step(1);
    check("mid_rel_idx0", 32'(anode_n), 32'h3E);

    // Table: each vector waits for a fresh snapshot, then samples its slot
    for (int v = 0; v < 16; v++) begin
      count = vecs[v].count;
      wait_frame($sformatf("vec%0d_frame", v));
      step(1 + 4 * vecs[v].idx);
      check($sformatf("vec%0d_dead", v), 32'(anode_n), 32'h3F);
      step(1);
      check($sformatf("vec%0d_anode", v), 32'(anode_n), 32'(vecs[v].anode));
      check($sformatf("vec%0d_seg", v),   32'(seg_n),   32'(vecs[v].seg));
      check($sformatf("vec%0d_dp", v),    32'(dp_n),    32'(vecs[v].dp));
    end

    // Frame period
    wait_frame("period_sync");
    frame_gap(gap);
    check("frame_period", 32'(gap), 32'd24);

    // Tearing: count changes while index 3 is on screen
    count = 24'h000000;
    wait_frame("tear_sync");
    step(14);
    count = 24'h599999;
    step(4);
    check("tear_idx4_seg", 32'(seg_n), 32'h40);
    step(4);
    check("tear_idx5_anode", 32'(anode_n), 32'h1F);
    check("tear_idx5_seg",   32'(seg_n),   32'h40);
    step(2);
    check("tear_frame", 32'(frame), 32'h1);
    step(2);
    check("tear_new_idx0_seg", 32'(seg_n), 32'h10);
    step(20);
    check("tear_new_idx5_seg", 32'(seg_n), 32'h12);

    // Blank for 10 cycles spanning a frame boundary
    count = 24'h012345;
    wait_frame("blank_sync");
    step(20);
    blank = 1'b1;
    seen_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check($sformatf("blank_anode_c%0d", i), 32'(anode_n), 32'h3F);
      if (frame) seen_at = i;
    end
    check("blank_frame_on_time", 32'(seen_at), 32'd4);
    blank = 1'b0;
    step(1);
    check("unblank_idx1_anode", 32'(anode_n), 32'h3D);
    frame_gap(gap);
    check("unblank_next_frame", 32'(gap), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_sevensegmux.md
RTC_SEVENSEGMUX -- requirements
Module: rtc_sevensegmux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, i_clk cycles per digit slot (legal range 2 to 2^20).
REQ-002 SHALL have port i_clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_count, input, 24, BCD time, nibble 0 = 10 ms digit, nibble 5 = tens of minutes (stopwatch counter output).
REQ-005 SHALL have port i_blank, input, 1, when high all anodes off.
REQ-006 SHALL have port o_anode_n, output, 6, active-low digit enables, bit k drives nibble k.
REQ-007 SHALL have port o_seg_n, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-008 SHALL have port o_dp_n, output, 1, active-low decimal point.
REQ-009 SHALL have port o_frame, output, 1, one-cycle pulse when a new i_count snapshot is taken.

Function
REQ-010 SHALL hold a slot counter that counts 0..REFRESH_DIV-1 and wraps to 0; its width is the ceiling of log2(REFRESH_DIV).
REQ-011 SHALL advance the 3-bit digit index 0,1,2,3,4,5,0 on each slot-counter wrap; values 6 and 7 are never reached.
REQ-012 SHALL copy i_count into a 24-bit snapshot register and pulse o_frame in the same cycle the index wraps 5->0, so one scan frame never shows torn digits.
REQ-013 SHALL source all displayed digits from the snapshot only, never directly from i_count.
REQ-014 SHALL register o_anode_n, o_seg_n and o_dp_n; they reflect the current index one cycle after the index changes.
REQ-015 SHALL drive o_anode_n to all ones while the slot counter equals 0, giving one dead cycle per slot against ghosting.
REQ-016 SHALL otherwise drive exactly one o_anode_n bit low, at the current index.
REQ-017 SHALL decode BCD 0-9 to standard seven-segment patterns (0 = 1000000, 1 = 1111001, 8 = 0000000, active-low g..a).
REQ-018 SHALL display nibble values 10-15 as a dash (0111111).
REQ-019 SHALL drive o_dp_n low only at index 2 (seconds.ms) and index 4 (minutes.seconds); high elsewhere.
REQ-020 SHALL force o_anode_n to all ones on the next cycle while i_blank is high; scanning and snapshotting continue unaffected.
REQ-021 SHALL accept i_count changing at any cycle; changes between snapshots are ignored.

Reset
REQ-022 SHALL, while i_reset is high, asynchronously set:
- slot counter 0
- index 0
- snapshot 0
- o_anode_n 111111
- o_seg_n 1111111
- o_dp_n 1
- o_frame 0
REQ-023 SHALL take the first snapshot at the first 5->0 index wrap after reset release; digits display zero until then.
REQ-024 SHALL abort a reset asserted mid-slot immediately with no partial-frame completion.

Configuration
REQ-025 SHALL, when macro RTC_LZBLANK_EN is defined, blank leading zeros: index 5 blanks if its nibble is 0; index 4 blanks if nibbles 5 and 4 are 0; index 3 blanks if nibbles 5-3 are 0. Index 2-0 are never blanked, and the dp follows its digit's blanking.
REQ-026 SHALL, when RTC_LZBLANK_EN is undefined, display all six digits unconditionally; blanking logic is not compiled.

Verification (REFRESH_DIV=4)
REQ-027 SHALL check reset: assert i_reset mid-scan -> same cycle o_anode_n=111111, o_seg_n=1111111, o_dp_n=1; after release, index 0 selected on cycle 2.
REQ-028 SHALL check scan order: i_count=24'h012345 held -> anodes low in order bit0..bit5, each 3 cycles with 1 dead cycle. Segments show 5,4,3,2,1,0; dp low on bits 2 and 4; o_frame pulses every 24 cycles.
REQ-029 SHALL check tearing: change i_count from 24'h000000 to 24'h599999 while index is 3 -> remaining digits of the frame show 0, and the next frame shows 5,9,9,9,9,9.
REQ-030 SHALL check invalid BCD: i_count=24'hFA0000 -> indices 5 and 4 show dash 0111111.
REQ-031 SHALL check blanking with RTC_LZBLANK_EN: i_count=24'h000512 -> indices 5,4,3 anodes stay high; digits 5.1.2 are shown. Without the macro, all six are shown.
REQ-032 SHALL check i_blank: i_blank=1 for 10 cycles -> o_anode_n=111111 throughout; o_frame pulses continue on schedule.
